// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the device.
// The sequence is: hold the clock low (inhibit), request-to-send with the
// start bit, shift out 8 data bits LSB first plus odd parity and the stop
// bit on device-generated falling clock edges, then check the device ack.
// Both lines are open-collector. The top level forms
// line = drive_low ? 0 : Z and shares the lines with the existing receiver.
//
// Ports:
//   clk                 system clock (100 MHz)
//   rst_n               asynchronous active-low reset
//   tx_data[7:0]        command byte, taken when tx_valid && tx_ready
//   tx_valid            send request
//   tx_ready            high only while idle
//   ps2_clk_in          raw PS/2 clock line level (asynchronous)
//   ps2_data_in         raw PS/2 data line level (asynchronous)
//   ps2_clk_drive_low   1 = pull PS/2 clock low
//   ps2_data_drive_low  1 = pull PS/2 data low
//   busy                high in every state except idle
//   done                one-cycle pulse on an acked transfer
//   error               one-cycle pulse on nack or timeout
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 12000,
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter int unsigned FILTER_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_drive_low,
   output logic       ps2_data_drive_low,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      XFER,
      WAIT_IDLE,
      ABORT
   } state_t;

   // Bit 0 = PS/2 clock, bit 1 = PS/2 data.
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    filt;
   logic [FW-1:0] fcnt [2];
   logic          clk_filt_d;
   logic          fall;

   state_t        state;
   logic [8:0]    shreg;     // {parity, data}; bit 0 goes out next
   logic [3:0]    bitn;
   logic [IW-1:0] icnt;
   logic [TW-1:0] tcnt;
   logic          timeout;

   // Lines idle high; filters come out of reset already at the idle level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= '1;
         sync2      <= '1;
         filt       <= '1;
         fcnt[0]    <= '0;
         fcnt[1]    <= '0;
         clk_filt_d <= 1'b1;
      end else begin
         sync1      <= {ps2_data_in, ps2_clk_in};
         sync2      <= sync1;
         clk_filt_d <= filt[0];
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FW'(FILTER_CYCLES - 1)) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   assign fall    = clk_filt_d & ~filt[0];
   assign timeout = (tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         shreg              <= '0;
         bitn               <= '0;
         icnt               <= '0;
         tcnt               <= '0;
         tx_ready           <= 1'b1;
         busy               <= 1'b0;
         done               <= 1'b0;
         error              <= 1'b0;
         ps2_clk_drive_low  <= 1'b0;
         ps2_data_drive_low <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  shreg             <= {~^tx_data, tx_data};
                  icnt              <= '0;
                  ps2_clk_drive_low <= 1'b1;
                  tx_ready          <= 1'b0;
                  busy              <= 1'b1;
                  state             <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
                  ps2_data_drive_low <= 1'b1;   // start bit
                  state              <= RTS;
               end else begin
                  icnt <= icnt + 1'b1;
               end
            end
            RTS: begin
               ps2_clk_drive_low <= 1'b0;
               tcnt              <= '0;
               bitn              <= '0;
               state             <= XFER;
            end
            XFER: begin
               tcnt <= tcnt + 1'b1;
               // Timeout is tested first so it wins over a same-cycle fall.
               if (timeout) begin
                  ps2_data_drive_low <= 1'b0;
                  state              <= ABORT;
               end else if (fall) begin
                  bitn <= bitn + 1'b1;
                  if (bitn < 4'd9) begin
                     ps2_data_drive_low <= ~shreg[0];
                     shreg              <= {1'b0, shreg[8:1]};
                  end else if (bitn == 4'd9) begin
                     ps2_data_drive_low <= 1'b0;   // stop bit: release
                  end else if (filt[1]) begin
                     state <= ABORT;                // nack
                  end else begin
                     state <= WAIT_IDLE;
                  end
               end
            end
            WAIT_IDLE: begin
               tcnt <= tcnt + 1'b1;
               if (timeout) begin
                  state <= ABORT;
               end else if (filt == 2'b11) begin
                  done     <= 1'b1;
                  tx_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            ABORT: begin
               ps2_clk_drive_low  <= 1'b0;
               ps2_data_drive_low <= 1'b0;
               error              <= 1'b1;
               tx_ready           <= 1'b1;
               busy               <= 1'b0;
               state              <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

   localparam int unsigned INH = 300;
   localparam int unsigned TMO = 4000;
   localparam int unsigned FLT = 8;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic [7:0] tx_data  = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       clk_dl;
   logic       data_dl;
   logic       busy;
   logic       done;
   logic       error;

   // Device side of the open-collector wires.
   logic dev_clk  = 1'b1;
   logic dev_data = 1'b1;
   assign ps2_clk_in  = dev_clk  & ~clk_dl;
   assign ps2_data_in = dev_data & ~data_dl;

   int unsigned tests = 0;
   int unsigned fails = 0;

   int unsigned done_tot = 0;
   int unsigned err_tot  = 0;
   logic        pulse_d     = 1'b0;
   logic        ready_after = 1'b0;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO),
      .FILTER_CYCLES  (FLT)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .tx_data            (tx_data),
      .tx_valid           (tx_valid),
      .tx_ready           (tx_ready),
      .ps2_clk_in         (ps2_clk_in),
      .ps2_data_in        (ps2_data_in),
      .ps2_clk_drive_low  (clk_dl),
      .ps2_data_drive_low (data_dl),
      .busy               (busy),
      .done               (done),
      .error              (error)
   );

   always #5 clk = ~clk;

   // Running pulse totals and tx_ready one cycle after each done/error.
   always @(posedge clk) begin
      if (done)  done_tot <= done_tot + 1;
      if (error) err_tot  <= err_tot + 1;
      pulse_d <= done | error;
      if (pulse_d) ready_after <= tx_ready;
   end

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      tests++;
      if (obs != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected line frame: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] frame_of(input logic [7:0] b);
      int unsigned ones;
      logic [10:0] f;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += b[i];
      f[0]    = 1'b0;
      f[8:1]  = b;
      f[9]    = (ones % 2 == 0);
      f[10]   = 1'b1;
      return f;
   endfunction

   task automatic start_req(input logic [7:0] b);
      int unsigned lowcnt;
      @(negedge clk);
      check_eq("ready_before", tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check_eq("busy_after_accept", busy, 1);
      lowcnt = 0;
      while (clk_dl && lowcnt < INH + 100) begin
         lowcnt++;
         @(negedge clk);
      end
      // INHIBIT_CYCLES of inhibit plus the one request-to-send cycle.
      check_eq("clk_low_len", lowcnt, INH + 1);
      check_eq("start_bit_line", ps2_data_in, 0);
   endtask

   // Device: 11 clocks, sample on each rise; optionally ack, glitch, or reset.
   task automatic device_clocks(input bit ack, input bit glitch, input int rst_at,
                                output logic [10:0] fr, output bit was_reset);
      int unsigned hi, lo;
      fr        = '0;
      fr[0]     = ps2_data_in;
      was_reset = 1'b0;
      for (int k = 0; k < 11; k++) begin
         if (!was_reset) begin
            hi = $urandom_range(30, 50);
            lo = $urandom_range(30, 50);
            if (k == rst_at) begin
               check_eq("pre_rst_data_dl", data_dl, 1);
               #2 rst_n = 1'b0;
               #1;
               check_eq("rst_clk_dl", clk_dl, 0);
               check_eq("rst_data_dl", data_dl, 0);
               check_eq("rst_busy", busy, 0);
               check_eq("rst_ready", tx_ready, 1);
               repeat (3) @(negedge clk);
               rst_n     = 1'b1;
               was_reset = 1'b1;
            end else begin
               if (k == 10 && ack) dev_data = 1'b0;
               if (glitch && (k == 2 || k == 5)) begin
                  repeat (15) @(negedge clk);
                  dev_clk = 1'b0;
                  repeat (3) @(negedge clk);
                  dev_clk = 1'b1;
               end
               repeat (hi) @(negedge clk);
               dev_clk = 1'b0;
               repeat (lo) @(negedge clk);
               dev_clk = 1'b1;
               if (k < 10) fr[k+1] = ps2_data_in;
            end
         end
      end
      if (!was_reset) repeat (5) @(negedge clk);
      dev_data = 1'b1;
      dev_clk  = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ack, input bit glitch);
      int unsigned d0, e0;
      logic [10:0] fr, ex;
      bit          rs;
      d0 = done_tot;
      e0 = err_tot;
      start_req(b);
      device_clocks(ack, glitch, 99, fr, rs);
      repeat (60) @(negedge clk);
      ex = frame_of(b);
      check_eq("frame", fr, ex);
      check_eq("parity", fr[9], ex[9]);
      check_eq("done_cnt", done_tot - d0, ack ? 1 : 0);
      check_eq("error_cnt", err_tot - e0, ack ? 0 : 1);
      check_eq("ready_after_pulse", ready_after, 1);
      check_eq("idle_clk_dl", clk_dl, 0);
      check_eq("idle_data_dl", data_dl, 0);
      check_eq("idle_busy", busy, 0);
   endtask

   task automatic timeout_test(input logic [7:0] b);
      int unsigned d0, e0, n;
      d0 = done_tot;
      e0 = err_tot;
      start_req(b);
      n = 0;
      while (!error && n < TMO + 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("timeout_len", n, TMO + 1);
      check_eq("timeout_clk_dl", clk_dl, 0);
      check_eq("timeout_data_dl", data_dl, 0);
      repeat (3) @(negedge clk);
      check_eq("timeout_done_cnt", done_tot - d0, 0);
      check_eq("timeout_error_cnt", err_tot - e0, 1);
      check_eq("timeout_ready", tx_ready, 1);
   endtask

   task automatic reset_test(input logic [7:0] b);
      int unsigned d0, e0;
      logic [10:0] fr;
      bit          rs;
      d0 = done_tot;
      e0 = err_tot;
      start_req(b);
      device_clocks(1'b1, 1'b0, 4, fr, rs);
      check_eq("reset_hit", rs, 1);
      repeat (60) @(negedge clk);
      check_eq("rst_done_cnt", done_tot - d0, 0);
      check_eq("rst_error_cnt", err_tot - e0, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rb;
      repeat (3) @(negedge clk);
      check_eq("reset_ready", tx_ready, 1);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_error", error, 0);
      check_eq("reset_clk_dl", clk_dl, 0);
      check_eq("reset_data_dl", data_dl, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      send_byte(8'hED, 1'b1, 1'b0);
      send_byte(8'h00, 1'b1, 1'b0);
      send_byte(8'hFF, 1'b1, 1'b0);
      send_byte(8'h01, 1'b1, 1'b0);
      rb = 8'($urandom);
      send_byte(rb, 1'b0, 1'b0);
      timeout_test(8'hFF);
      send_byte(8'h55, 1'b1, 1'b1);
      rb = 8'($urandom) & 8'hF7;
      reset_test(rb);
      send_byte(8'hF4, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         rb = 8'($urandom);
         send_byte(rb, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send direction of the keyboard port, which is otherwise receive-only.
- Accepts one command byte at a time (e.g. 0xED set-LEDs, 0xFF reset) and performs the open-collector host-request sequence: inhibit, request-to-send, 11 device-clocked bits and the ack check.
- The top level combines its drive-low outputs with the existing receiver onto the PS2KeyboardClk/PS2KeyboardData inouts: line = drive_low ? 0 : Z.

Parameters:
- INHIBIT_CYCLES, 12000, clk cycles the host holds PS/2 clock low before request-to-send (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000, maximum clk cycles from clock release to ack completion before abort (20 ms).
- FILTER_CYCLES, 8, consecutive equal synchronized samples required before a PS/2 line level is accepted.

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- tx_data  input  8  command byte to send
- tx_valid  input  1  request; byte is accepted when tx_valid && tx_ready
- tx_ready  output  1  high only in IDLE
- ps2_clk_in  input  1  raw PS/2 clock line level (asynchronous)
- ps2_data_in  input  1  raw PS/2 data line level (asynchronous)
- ps2_clk_drive_low  output  1  1 = pull PS/2 clock low
- ps2_data_drive_low  output  1  1 = pull PS/2 data low
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on successful acked transfer
- error  output  1  one-cycle pulse on nack or timeout

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; tx_ready = 1.
  - busy, done, error, ps2_clk_drive_low and ps2_data_drive_low all 0.
  - Filters preset to 1; all counters 0.
- Input conditioning:
  - Each PS/2 line passes a 2-flop synchronizer, then the filter.
  - Filtered level changes only after FILTER_CYCLES identical samples.
  - fall = filtered clock 1->0, single-cycle strobe.
- Accept: in IDLE with tx_valid = 1, latch tx_data into shift register; parity = ~^tx_data (odd); go to INHIBIT next cycle. tx_valid is ignored outside IDLE.
- INHIBIT: clk_drive_low = 1 for exactly INHIBIT_CYCLES cycles, then -> RTS.
- RTS: one cycle with clk_drive_low = 1 and data_drive_low = 1 (start bit). Next cycle clk_drive_low = 0, timeout counter cleared, -> XFER.
- XFER (bit counter n = 0..10, advanced only on fall):
  - fall n = 0..7: data_drive_low = ~data bit n, LSB first.
  - fall 8: data_drive_low = ~parity.
  - fall 9: data_drive_low = 0 (stop bit, line released).
  - fall 10: sample filtered data. 0 -> WAIT_IDLE; 1 -> nack -> ABORT.
- WAIT_IDLE: when filtered clock = 1 and filtered data = 1, pulse done, -> IDLE.
- Timeout:
  - Counter runs in XFER and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES -> ABORT.
  - If fall arrives on the same cycle as the timeout, the timeout wins.
- ABORT: both drive_low outputs = 0; error pulses for 1 cycle; -> IDLE.
- At most one of done/error pulses per accepted byte.
- Drive outputs are registered.
- clk_drive_low is never asserted outside INHIBIT/RTS. data_drive_low is never asserted outside RTS/XFER.
- Reset mid-operation: both lines released in the same cycle as rst_n falls (asynchronous); no done or error pulse.
- Back-to-back: tx_ready returns 1 on the cycle after done or error.

Test Plan:
- 0xED with bench device model acking:
  - clock low 12000 cycles, then start bit 0.
  - Bits sampled on device rising edges: 1,0,1,1,0,1,1,1; parity 1; stop 1.
  - Device drives ack low -> done pulses once, error stays 0, tx_ready = 1 next cycle.
- Parity corners, each acked:
  - 0x00 -> parity 1; 0xFF -> parity 1; 0x01 -> parity 0.
  - Model checks parity and bit order for each.
- Nack: device leaves data high at the 11th clock -> error pulses once, done = 0, both drive_low = 0, state IDLE.
- Timeout: device never clocks after RTS -> error pulses exactly TIMEOUT_CYCLES (+/- filter latency) after clock release; lines released.
- Glitch rejection: inject 3-cycle low glitches on ps2_clk_in during XFER -> bit counter unchanged, transfer of 0x55 still completes correctly.
- Reset mid-XFER after 4 bits: rst_n low -> both drive_low = 0 immediately, busy = 0, no done/error. A following 0xF4 transfer completes normally.
